// File: rtl/mem_pixel_writer.sv
// mem_pixel_writer: turns 8-bit RGB332 pixel writes into masked 32-bit MCB word writes.
// Define PIXEL_COALESCE_EN to enable merging of same-word pixels (HOLD state, flush, timeout).

module mem_pixel_lane (
    input  logic       clk,
    input  logic       rst,
    input  logic       hit,
    input  logic       clr,
    input  logic [7:0] color,
    output logic [7:0] data,
    output logic       mask
);
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
            mask <= 1'b1;
        end else if (hit) begin
            data <= color;
            mask <= 1'b0;
        end else if (clr) begin
            data <= '0;
            mask <= 1'b1;
        end
    end
endmodule

module mem_pixel_writer #(
    parameter logic [29:0] BASE_ADDR = 30'h0000_0000,
    parameter int          TIMEOUT   = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    output logic        pix_ready,
    input  logic [15:0] pix_addr,
    input  logic [7:0]  pix_color,
    input  logic        flush,
    output logic        mem_cmd_en,
    output logic [2:0]  mem_cmd_instr,
    output logic [5:0]  mem_cmd_bl,
    output logic [29:0] mem_cmd_byte_addr,
    input  logic        mem_cmd_full,
    output logic        mem_wr_en,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    input  logic        mem_wr_full,
    input  logic        mem_wr_underrun,
    input  logic        mem_wr_error,
    output logic        busy,
    output logic        err
);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, HOLD, PUSH, CMD} state_t;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [1:0]  lane;
        logic        oor;
    } pix_req_t;

    state_t   state, state_n;
    pix_req_t req;
    logic     load, merge;
    logic     wr_en_d, cmd_en_d;
    logic [NUM_LANES-1:0]       lane_hit, lane_clr, lane_mask;
    logic [NUM_LANES-1:0][7:0]  lane_data;

`ifdef PIXEL_COALESCE_EN
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);
    logic [7:0] tmo, tmo_n;
    logic       same_word;
    assign same_word = (req.word_addr == mem_cmd_byte_addr);
`else
    localparam int unused_timeout = TIMEOUT;
    logic unused_flush;
    assign unused_flush = flush;
`endif

    // Base is word aligned, so the lane comes straight from the pixel index.
    always_comb begin
        req.word_addr = (BASE_ADDR + {14'd0, pix_addr}) & 30'h3FFF_FFFC;
        req.lane      = pix_addr[1:0];
        req.oor       = (pix_addr >= 16'd49152);
    end

    always_comb begin
        state_n   = state;
        pix_ready = 1'b0;
        load      = 1'b0;
        merge     = 1'b0;
        wr_en_d   = 1'b0;
        cmd_en_d  = 1'b0;
`ifdef PIXEL_COALESCE_EN
        tmo_n     = tmo;
`endif
        case (state)
            IDLE: begin
                pix_ready = 1'b1;
                if (pix_valid && !req.oor) begin
                    load = 1'b1;
`ifdef PIXEL_COALESCE_EN
                    state_n = HOLD;
                    tmo_n   = TMO_LOAD;
`else
                    state_n = PUSH;
                    wr_en_d = !mem_wr_full;
`endif
                end
            end
`ifdef PIXEL_COALESCE_EN
            HOLD: begin
                pix_ready = req.oor || same_word;
                merge     = pix_valid && !req.oor && same_word;
                if (merge)
                    tmo_n = TMO_LOAD;
                else if (tmo != 8'd0)
                    tmo_n = tmo - 8'd1;
                // A coinciding same-word pixel merges on the same edge it leaves HOLD.
                if ((pix_valid && !req.oor && !same_word) || flush ||
                    (!merge && tmo <= 8'd1) || (mem_wr_mask == 4'h0)) begin
                    state_n = PUSH;
                    wr_en_d = !mem_wr_full;
                end
            end
`endif
            PUSH: begin
                if (mem_wr_en) begin
                    state_n  = CMD;
                    cmd_en_d = !mem_cmd_full;
                end else begin
                    wr_en_d = !mem_wr_full;
                end
            end
            CMD: begin
                if (mem_cmd_en)
                    state_n = IDLE;
                else
                    cmd_en_d = !mem_cmd_full;
            end
            default: state_n = IDLE;
        endcase
        if (rst)
            pix_ready = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            mem_wr_en         <= 1'b0;
            mem_cmd_en        <= 1'b0;
            mem_cmd_byte_addr <= '0;
            err               <= 1'b0;
        end else begin
            state      <= state_n;
            mem_wr_en  <= wr_en_d;
            mem_cmd_en <= cmd_en_d;
            if (load)
                mem_cmd_byte_addr <= req.word_addr;
            err <= err | mem_wr_underrun | mem_wr_error;
        end
    end

`ifdef PIXEL_COALESCE_EN
    always_ff @(posedge clk) begin
        if (rst)
            tmo <= TMO_LOAD;
        else
            tmo <= tmo_n;
    end
`endif

    genvar n;
    generate
        for (n = 0; n < NUM_LANES; n++) begin : g_lane
            assign lane_hit[n] = (load || merge) && (req.lane == 2'(n));
            assign lane_clr[n] = load && (req.lane != 2'(n));
            mem_pixel_lane u_lane (
                .clk   (clk),
                .rst   (rst),
                .hit   (lane_hit[n]),
                .clr   (lane_clr[n]),
                .color (pix_color),
                .data  (lane_data[n]),
                .mask  (lane_mask[n])
            );
        end
    endgenerate

    assign mem_wr_data   = lane_data;
    assign mem_wr_mask   = lane_mask;
    assign mem_cmd_instr = 3'b000;
    assign mem_cmd_bl    = 6'd0;
    assign busy          = !rst && (state != IDLE);
endmodule
